// File: rtl/lp_tx_serializer_if.sv
// Byte-stream handshake between a payload source and the serializer.
// Suffixes name the direction as seen from the serializer.
interface lp_tx_serializer_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, output last_i, input ready_o);
  modport slave  (input data_i, input valid_i, input last_i, output ready_o);
endinterface

// File: rtl/lp_tx_serializer.sv
// Frame serializer: sync byte, payload bytes LSB first at two bits per cycle, then a trail.
// The line outputs come straight from flops so the DDR stage sees no input-to-output path.
module lp_tx_serializer #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned TRAIL_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lp_tx_serializer_if.slave in_if,
  output logic [1:0]        bits_o,
  output logic              active_o,
  output logic              underflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_DATA  = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  localparam logic [3:0] TRAIL_LOAD = 4'(TRAIL_CYCLES - 1);
  localparam logic [1:0] CNT_LAST   = 2'd3;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] trail_q, trail_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_last_q, hold_last_d;
  logic       last_seen_q, last_seen_d;
  logic       cur_last_q, cur_last_d;
  logic       active_q, active_d;
  logic       underflow_q, underflow_d;
  logic       in_frame_s, ready_s, hs_s, boundary_s;

  assign in_frame_s    = (state_q == ST_SYNC) || (state_q == ST_DATA);
  assign ready_s       = in_frame_s && !hold_full_q && !last_seen_q;
  assign hs_s          = in_if.valid_i && ready_s;
  assign boundary_s    = in_frame_s && (cnt_q == CNT_LAST);
  assign in_if.ready_o = ready_s;
  assign bits_o        = sr_q[1:0];
  assign active_o      = active_q;
  assign underflow_o   = underflow_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset also drops any held byte.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sr_q        <= 8'h00;
      hold_q      <= 8'h00;
      cnt_q       <= 2'd0;
      trail_q     <= 4'd0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      last_seen_q <= 1'b0;
      cur_last_q  <= 1'b0;
      active_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      trail_q     <= trail_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      last_seen_q <= last_seen_d;
      cur_last_q  <= cur_last_d;
      active_q    <= active_d;
      underflow_q <= underflow_d;
    end
  end

  // Next-state logic; at a byte boundary a pending or bypassing byte keeps the frame going.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_if.valid_i) state_d = ST_SYNC;
        else               state_d = ST_IDLE;
      end
      ST_SYNC, ST_DATA: begin
        if (!boundary_s)                 state_d = state_q;
        else if (hold_full_q || hs_s)    state_d = ST_DATA;
        else                             state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        if (trail_q == 4'd0) state_d = ST_IDLE;
        else                 state_d = ST_TRAIL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register next values; the trail is held in sr as the inverse of the final line bit.
  always_comb begin
    sr_d        = sr_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    trail_d     = trail_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    last_seen_d = last_seen_q;
    cur_last_d  = cur_last_q;
    active_d    = active_q;
    underflow_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d       = 2'd0;
        trail_d     = 4'd0;
        hold_full_d = 1'b0;
        hold_last_d = 1'b0;
        last_seen_d = 1'b0;
        cur_last_d  = 1'b0;
        if (in_if.valid_i) begin
          sr_d     = SYNC_BYTE;
          active_d = 1'b1;
        end else begin
          sr_d     = 8'h00;
          active_d = 1'b0;
        end
      end
      ST_SYNC, ST_DATA: begin
        active_d = 1'b1;
        if (boundary_s) begin
          cnt_d = 2'd0;
          if (hold_full_q) begin
            sr_d        = hold_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            hold_last_d = 1'b0;
          end else if (hs_s) begin
            sr_d        = in_if.data_i;
            cur_last_d  = in_if.last_i;
            last_seen_d = last_seen_q | in_if.last_i;
          end else begin
            sr_d        = {8{~sr_q[1]}};
            trail_d     = TRAIL_LOAD;
            underflow_d = ~cur_last_q;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
          sr_d  = {2'b00, sr_q[7:2]};
          if (hs_s) begin
            hold_d      = in_if.data_i;
            hold_full_d = 1'b1;
            hold_last_d = in_if.last_i;
            last_seen_d = last_seen_q | in_if.last_i;
          end else begin
            hold_d      = hold_q;
            hold_full_d = hold_full_q;
          end
        end
      end
      ST_TRAIL: begin
        if (trail_q == 4'd0) begin
          sr_d     = 8'h00;
          active_d = 1'b0;
        end else begin
          trail_d  = trail_q - 4'd1;
          active_d = 1'b1;
        end
      end
      default: begin
        sr_d        = 8'h00;
        cnt_d       = 2'd0;
        trail_d     = 4'd0;
        hold_full_d = 1'b0;
        hold_last_d = 1'b0;
        last_seen_d = 1'b0;
        cur_last_d  = 1'b0;
        active_d    = 1'b0;
      end
    endcase
  end

endmodule
